// File: rtl/tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : tx_framer
// Purpose  : Payload FIFO and word-paced framer (SOF, payload, optional CRC-8)
//            that feeds an 8b/10b encoder. Optional CRC via TX_FRAMER_CRC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tx_framer #(
  parameter int         FIFO_DEPTH = 16,
  parameter int         MIN_IDLE   = 4,
  parameter logic [7:0] SOF_BYTE   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       word_en,
  output logic [7:0] enc_data,
  output logic       enc_idle,
  output logic       busy,
  output logic       underrun
);

  localparam int                  c_ADDR_W   = $clog2(FIFO_DEPTH);
  localparam logic [c_ADDR_W:0]   c_DEPTH    = (c_ADDR_W + 1)'(FIFO_DEPTH);
  localparam logic [7:0]          c_MIN_IDLE = 8'(MIN_IDLE);

`ifdef TX_FRAMER_CRC_EN
  typedef enum logic [1:0] {
    ST_GAP     = 2'd0,
    ST_SOF     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CRC     = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_GAP     = 2'd0,
    ST_SOF     = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;
`endif

  logic [8:0]          r_mem [FIFO_DEPTH];
  logic [c_ADDR_W:0]   r_wr_ptr;
  logic [c_ADDR_W:0]   r_rd_ptr;
  logic [c_ADDR_W:0]   r_frames;
  logic                r_in_ready;
  logic [c_ADDR_W:0]   w_count;
  logic [c_ADDR_W:0]   w_count_nxt;
  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic                w_pop;
  logic [8:0]          w_rd_entry;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_gap;
  logic [7:0]          w_gap_nxt;
  logic [7:0]          r_enc_data;
  logic [7:0]          w_data_nxt;
  logic                r_enc_idle;
  logic                w_idle_nxt;
  logic                r_underrun;
  logic                w_underrun_nxt;

  assign w_count     = r_wr_ptr - r_rd_ptr;
  assign w_empty     = (w_count == '0);
  assign w_full      = (w_count == c_DEPTH);
  assign w_push      = in_valid & r_in_ready;
  assign w_rd_entry  = r_mem[r_rd_ptr[c_ADDR_W-1:0]];
  assign w_count_nxt = w_count + {{c_ADDR_W{1'b0}}, w_push} - {{c_ADDR_W{1'b0}}, w_pop};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= {in_last, in_data};
    end
  end

  // in_ready is registered from the post-update occupancy so it always equals !full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_in_ready <= 1'b1;
      r_frames   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_in_ready <= (w_count_nxt != c_DEPTH);
      case ({w_push & in_last, w_pop & w_rd_entry[8]})
        2'b10:   r_frames <= r_frames + 1'b1;
        2'b01:   r_frames <= r_frames - 1'b1;
        default: r_frames <= r_frames;
      endcase
    end
  end

`ifdef TX_FRAMER_CRC_EN
  logic [7:0] r_crc;
  logic [7:0] w_crc_nxt;

  function automatic logic [7:0] f_crc8(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      c = {c[6:0], 1'b0} ^ (((c[7] ^ d[i]) == 1'b1) ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_crc <= 8'h00;
    else     r_crc <= w_crc_nxt;
  end
`endif

  // The state names the word to be presented at the next word_en edge
  always_comb begin
    w_state_nxt    = r_state;
    w_gap_nxt      = r_gap;
    w_data_nxt     = r_enc_data;
    w_idle_nxt     = r_enc_idle;
    w_underrun_nxt = 1'b0;
    w_pop          = 1'b0;
`ifdef TX_FRAMER_CRC_EN
    w_crc_nxt      = r_crc;
`endif
    if (word_en) begin
      case (r_state)
        ST_GAP: begin
          w_idle_nxt = 1'b1;
          w_data_nxt = 8'h00;
          if ((r_gap >= c_MIN_IDLE) && ((r_frames != '0) || w_full)) begin
            w_state_nxt = ST_SOF;
          end else if (r_gap < c_MIN_IDLE) begin
            w_gap_nxt = r_gap + 8'd1;
          end
        end
        ST_SOF: begin
          w_idle_nxt  = 1'b0;
          w_data_nxt  = SOF_BYTE;
          w_state_nxt = ST_PAYLOAD;
`ifdef TX_FRAMER_CRC_EN
          w_crc_nxt   = 8'h00;
`endif
        end
        ST_PAYLOAD: begin
          if (w_empty) begin
            w_idle_nxt     = 1'b1;
            w_data_nxt     = 8'h00;
            w_underrun_nxt = 1'b1;
            w_state_nxt    = ST_GAP;
            w_gap_nxt      = 8'd1;
          end else begin
            w_pop      = 1'b1;
            w_idle_nxt = 1'b0;
            w_data_nxt = w_rd_entry[7:0];
`ifdef TX_FRAMER_CRC_EN
            w_crc_nxt  = f_crc8(r_crc, w_rd_entry[7:0]);
            if (w_rd_entry[8]) w_state_nxt = ST_CRC;
`else
            if (w_rd_entry[8]) begin
              w_state_nxt = ST_GAP;
              w_gap_nxt   = 8'd1;
            end
`endif
          end
        end
`ifdef TX_FRAMER_CRC_EN
        ST_CRC: begin
          w_idle_nxt  = 1'b0;
          w_data_nxt  = r_crc;
          w_state_nxt = ST_GAP;
          w_gap_nxt   = 8'd1;
        end
`endif
        default: begin
          w_state_nxt = ST_GAP;
          w_gap_nxt   = 8'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_GAP;
      r_gap      <= 8'd0;
      r_enc_data <= 8'h00;
      r_enc_idle <= 1'b1;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gap      <= w_gap_nxt;
      r_enc_data <= w_data_nxt;
      r_enc_idle <= w_idle_nxt;
      r_underrun <= w_underrun_nxt;
    end
  end

  assign in_ready = r_in_ready;
  assign enc_data = r_enc_data;
  assign enc_idle = r_enc_idle;
  assign busy     = (r_state != ST_GAP);
  assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_framer
// Purpose  : Directed self-checking bench for tx_framer (CRC build follows
//            TX_FRAMER_CRC_EN); word_en strobes once every 10 clocks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       word_en;
  logic [7:0] enc_data;
  logic       enc_idle;
  logic       busy;
  logic       underrun;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q_data [$];
  logic       q_idle [$];
  logic       q_busy [$];
  logic       q_under[$];

`ifdef TX_FRAMER_CRC_EN
  localparam int c_CRC_WORDS = 1;
`else
  localparam int c_CRC_WORDS = 0;
`endif

  tx_framer #(.FIFO_DEPTH(16), .MIN_IDLE(4), .SOF_BYTE(8'hA5)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_last (in_last),
    .in_ready(in_ready),
    .word_en (word_en),
    .enc_data(enc_data),
    .enc_idle(enc_idle),
    .busy    (busy),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  initial begin
    word_en = 1'b0;
    forever begin
      repeat (9) @(negedge clk);
      word_en = 1'b1;
      @(negedge clk);
      word_en = 1'b0;
    end
  end

  // One log entry per line word, taken just after the edge that loads it
  always @(posedge clk) begin
    if (word_en) begin
      #1;
      q_data.push_back(enc_data);
      q_idle.push_back(enc_idle);
      q_busy.push_back(busy);
      q_under.push_back(underrun);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    q_data.delete();
    q_idle.delete();
    q_busy.delete();
    q_under.delete();
  endtask

  task automatic wait_words(input int n);
    int g;
    g = 0;
    while (q_data.size() < n && g < n * 12 + 40) begin
      @(negedge clk);
      g++;
    end
    if (q_data.size() < n) check("wait_words", q_data.size(), n);
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    int g;
    g = 0;
    while (!in_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) check("push_ready", in_ready, 1);
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  function automatic int first_word(input int from);
    for (int k = from; k < q_idle.size(); k++) begin
      if (!q_idle[k]) return k;
    end
    return -1;
  endfunction

  function automatic int count_busy();
    int n;
    n = 0;
    foreach (q_busy[k]) if (q_busy[k]) n++;
    return n;
  endfunction

  function automatic int count_under();
    int n;
    n = 0;
    foreach (q_under[k]) if (q_under[k]) n++;
    return n;
  endfunction

  initial begin
    int i;
    int e;
    int j;
    int bad;
    int g;

    rst      = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_idle",     enc_idle, 1);
    check("rst_data",     enc_data, 8'h00);
    check("rst_ready",    in_ready, 1);
    check("rst_busy",     busy,     0);
    check("rst_underrun", underrun, 0);
    rst = 1'b0;

    // No input: line stays idle
    clear_q();
    wait_words(30);
    check("idle_nonidle_words", first_word(0), 32'hFFFF_FFFF);
    check("idle_busy_words",    count_busy(), 0);
    check("idle_ready",         in_ready, 1);

    // Three-byte frame
    clear_q();
    push(8'h31, 1'b0);
    push(8'h32, 1'b0);
    push(8'h33, 1'b1);
    wait_words(25);
    i = first_word(0);
    check("a_found", (i >= 0), 1);
    if (i < 0) i = 0;
    check("a_sof",  q_data[i],   8'hA5);
    check("a_b0",   q_data[i+1], 8'h31);
    check("a_b1",   q_data[i+2], 8'h32);
    check("a_b2",   q_data[i+3], 8'h33);
`ifdef TX_FRAMER_CRC_EN
    check("a_crc",  q_data[i+4], 8'hC0);
    check("a_crc_valid", q_idle[i+4], 0);
`endif
    check("a_tail_idle", q_idle[i+4+c_CRC_WORDS], 1);
    check("a_no_more",   first_word(i + 5 + c_CRC_WORDS), 32'hFFFF_FFFF);
    check("a_busy_words", count_busy(), 4 + c_CRC_WORDS);

    // Two single-byte frames back to back
    clear_q();
    push(8'h01, 1'b1);
    push(8'h02, 1'b1);
    wait_words(40);
    i = first_word(0);
    check("b_found", (i >= 0), 1);
    if (i < 0) i = 0;
    check("b_sof0", q_data[i],   8'hA5);
    check("b_d0",   q_data[i+1], 8'h01);
`ifdef TX_FRAMER_CRC_EN
    check("b_crc0", q_data[i+2], 8'h07);
`endif
    e = i + 1 + c_CRC_WORDS;
    j = first_word(e + 1);
    check("b_gap_words", j - e - 1, 4);
    if (j < 0) j = 0;
    check("b_sof1", q_data[j],   8'hA5);
    check("b_d1",   q_data[j+1], 8'h02);
`ifdef TX_FRAMER_CRC_EN
    check("b_crc1", q_data[j+2], 8'h0E);
`endif

    // Over-long frame: fill the FIFO, producer stalls, cut-through then underrun
    clear_q();
    for (int k = 0; k < 16; k++) push(8'h40 + 8'(k), 1'b0);
    check("c_full_ready", in_ready, 0);
    wait_words(40);
    i = first_word(0);
    check("c_found", (i >= 0), 1);
    if (i < 0) i = 0;
    check("c_sof", q_data[i], 8'hA5);
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (q_idle[i+1+k] !== 1'b0 || q_data[i+1+k] !== 8'h40 + 8'(k)) bad++;
    end
    check("c_payload_errs", bad, 0);
    check("c_under_idle",  q_idle[i+17],  1);
    check("c_under_pulse", q_under[i+17], 1);
    check("c_under_count", count_under(), 1);
    check("c_no_more",     first_word(i + 18), 32'hFFFF_FFFF);
    check("c_ready_back",  in_ready, 1);

    // Reset in the middle of a five-byte frame
    clear_q();
    for (int k = 0; k < 5; k++) push(8'h61 + 8'(k), (k == 4));
    g = 0;
    while (!(enc_idle == 1'b0 && enc_data == 8'h61) && g < 400) begin
      @(negedge clk);
      g++;
    end
    check("d_payload_seen", enc_data, 8'h61);
    rst = 1'b1;
    #1;
    check("d_rst_idle",  enc_idle, 1);
    check("d_rst_data",  enc_data, 8'h00);
    check("d_rst_busy",  busy,     0);
    check("d_rst_ready", in_ready, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_q();
    wait_words(20);
    check("d_no_frame",  first_word(0), 32'hFFFF_FFFF);
    check("d_no_busy",   count_busy(), 0);
    check("d_ready",     in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tx_framer.md
TX_FRAMER -- requirements
Module: tx_framer

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, payload FIFO entries; power of two, at least 4.
REQ-002 Parameter MIN_IDLE, default 4, minimum idle words between frames and after reset; range 1..255.
REQ-003 Parameter SOF_BYTE, default 8'hA5, start-of-frame data byte.
REQ-004 clk  input  1  clock.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 in_data  input  8  payload byte.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_last  input  1  byte is the final payload byte of the frame.
REQ-009 in_ready  output  1  byte accepted when in_valid & in_ready at a clk edge.
REQ-010 word_en  input  1  one-clk strobe per 10-bit line word; same strobe drives the 8b/10b encoder's nextword_enable.
REQ-011 enc_data  output  8  byte to the encoder's d_in.
REQ-012 enc_idle  output  1  encoder emits a comma word instead of enc_data.
REQ-013 busy  output  1  frame in progress (SOF, PAYLOAD or CRC state).
REQ-014 underrun  output  1  one-clk pulse when a frame is aborted because the FIFO is empty mid-frame.

Function
REQ-015 The FIFO SHALL store {in_last, in_data}; in_ready = !full, registered.
REQ-016 The frame counter SHALL count stored entries with last=1: +1 on push of last, -1 on pop of last, unchanged when both occur in the same clk.
REQ-017 enc_data and enc_idle SHALL be registered and SHALL change only on clk edges where word_en=1, so the encoder samples the value presented during the preceding word.
REQ-018 States: GAP, SOF, PAYLOAD, CRC. All transitions SHALL occur only on word_en edges.
REQ-019 GAP: enc_idle=1. Gap counter increments per word, saturating at MIN_IDLE.
REQ-020 GAP->SOF when gap counter >= MIN_IDLE and either frame counter > 0 or FIFO full (cut-through for over-long frames).
REQ-021 SOF: enc_idle=0, enc_data=SOF_BYTE, CRC register cleared to 8'h00; next state PAYLOAD.
REQ-022 PAYLOAD: each word SHALL pop one entry, present its byte on enc_data and fold it into the CRC. A popped entry with last=1 SHALL lead to CRC (macro defined) or GAP (undefined).
REQ-023 PAYLOAD with FIFO empty at a word_en edge: enc_idle=1, underrun pulses, state GAP, gap counter reset to 1; the remaining bytes of that frame are then sent as a new frame.
REQ-024 CRC: enc_idle=0, enc_data=final CRC value; next state GAP with gap counter reset to 1.
REQ-025 Entering GAP from any state SHALL restart the gap count, so at least MIN_IDLE comma words separate frames.
REQ-026 A push and a pop on the same clk SHALL both take effect; FIFO occupancy is unchanged.
REQ-027 The FIFO SHALL not be written when full and SHALL not be read when empty.

Reset
REQ-028 On rst: state GAP, gap counter 0, FIFO empty, frame counter 0, CRC 0.
REQ-029 On rst: enc_idle=1, enc_data=8'h00, in_ready=1, busy=0, underrun=0.
REQ-030 rst asserted mid-frame SHALL discard FIFO contents and the frame in progress; no partial byte is presented after release.

Configuration
REQ-031 Macro TX_FRAMER_CRC_EN defined: the CRC state is used; CRC-8 uses polynomial x^8+x^2+x+1 (0x07), init 0x00, MSB-first, no reflection, no final XOR; the CRC covers payload bytes only.
REQ-032 TX_FRAMER_CRC_EN undefined: no CRC state or logic; the last payload byte is followed directly by GAP.

Verification
REQ-033 Reset release, no input, word_en every 10 clk -> enc_idle=1 continuously; in_ready=1; busy=0.
REQ-034 Push 0x31,0x32,0x33 (last on 0x33), CRC_EN defined -> after >=4 idle words: A5,31,32,33,CRC, then idle; CRC value matches the CRC-8 reference model.
REQ-035 Same stimulus, CRC_EN undefined -> A5,31,32,33 then idle; busy high for exactly 4 words.
REQ-036 Two 1-byte frames pushed back-to-back -> exactly MIN_IDLE=4 idle words between the first frame's final byte and the second A5.
REQ-037 20-byte frame, FIFO_DEPTH=16, producer stalls after 16 bytes -> in_ready=0 when full; frame starts by cut-through; underrun pulses once when the FIFO empties; then idle.
REQ-038 rst pulsed during PAYLOAD of a 5-byte frame -> next word idle, FIFO empty, frame counter 0, and no frame is sent afterward without new input.
